// File: rtl/mips_mem_arbiter.sv
// Arbiter for a shared single-port 1024x32 memory, serving instruction fetch and data load/store.
// Data has priority; a starvation counter lets fetch through. Reads return two cycles after grant.
module mips_mem_arbiter #(
  parameter int AW         = 10,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk1,
  input  logic          rst,
  input  logic          halted,
  input  logic          if_flush,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  logic [3:0] cnt;
  logic       if_eff;
  logic       if_ok;
  logic       d_act;
  logic       starved;
  logic       tag_f1;
  logic       tag_d1;
  logic       rv_f2;
  logic       rv_d2;

  // Fetch is eligible unless halted or in reset; a flush also blocks the grant
  // but the request still counts as waiting for starvation purposes.
  assign if_eff  = if_req & ~halted & ~rst;
  assign if_ok   = if_eff & ~if_flush;
  assign d_act   = d_req & ~rst;
  assign starved = (cnt == 4'(STARVE_MAX));

  assign if_gnt  = if_ok & (~d_act | starved);
  assign d_gnt   = d_act & ~(if_ok & starved);

  // A flush in the return cycle itself hides the fetch data being returned now.
  assign if_rvalid = rv_f2 & ~if_flush;
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rvalid  = rv_d2;
  assign d_rdata   = rv_d2 ? mem_rdata : '0;

  // Count consecutive cycles a live fetch request is refused; saturate at the limit.
  always_ff @(posedge clk1) begin
    if (rst) begin
      cnt <= '0;
    end else if (!if_eff || if_gnt) begin
      cnt <= '0;
    end else if (!starved) begin
      cnt <= cnt + 4'd1;
    end
  end

  // Register the winning access onto the memory port and tag what it was.
  always_ff @(posedge clk1) begin
    if (rst) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      tag_f1    <= 1'b0;
      tag_d1    <= 1'b0;
    end else begin
      mem_en <= if_gnt | d_gnt;
      mem_we <= d_gnt & d_we;
      tag_f1 <= if_gnt;
      tag_d1 <= d_gnt & ~d_we;
      if (if_gnt) begin
        mem_addr <= if_addr;
      end else if (d_gnt) begin
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
      end
    end
  end

  // Advance tags to the return stage; a flush kills the fetch one cycle behind.
  always_ff @(posedge clk1) begin
    if (rst) begin
      rv_f2 <= 1'b0;
      rv_d2 <= 1'b0;
    end else begin
      rv_f2 <= tag_f1 & ~if_flush;
      rv_d2 <= tag_d1;
    end
  end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Bench for mips_mem_arbiter: directed scenarios plus a random phase,
// with a scoreboard of expected read returns.
module tb_mips_mem_arbiter;

  logic        clk1 = 1'b0;
  logic        rst;
  logic        halted;
  logic        if_flush;
  logic        if_req;
  logic [9:0]  if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [9:0]  d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  mips_mem_arbiter #(.AW(10), .DW(32), .STARVE_MAX(4)) dut (
    .clk1(clk1), .rst(rst), .halted(halted), .if_flush(if_flush),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk1 = ~clk1;

  logic [31:0] mem [1024];
  logic [31:0] refm [1024];

  // memory device driven by the arbiter's port
  always @(posedge clk1) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else mem_rdata <= mem[mem_addr];
    end
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_on = 0;

  typedef struct {
    int          due;
    bit          f;
    logic [31:0] data;
  } exp_t;
  exp_t q[$];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk1) cyc <= cyc + 1;

  // scoreboard: drop cancelled returns, compare this cycle, record new grants
  always @(negedge clk1) begin
    if (mon_on) begin
      exp_t e;
      bit   ef;
      bit   ed;
      logic [31:0] ev;
      if (rst) begin
        for (int i = q.size() - 1; i >= 0; i--)
          if (q[i].due > cyc) q.delete(i);
      end
      if (if_flush) begin
        for (int i = q.size() - 1; i >= 0; i--)
          if (q[i].f && q[i].due <= cyc + 2) q.delete(i);
      end
      ef = 0;
      ed = 0;
      ev = '0;
      if (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        if (e.due == cyc) begin
          ef = e.f;
          ed = !e.f;
          ev = e.data;
        end else begin
          check("sb_late", 32'(e.due), 32'(cyc));
        end
      end
      check("sb_if_rvalid", {31'd0, if_rvalid}, {31'd0, ef});
      check("sb_if_rdata", if_rdata, ef ? ev : 32'd0);
      check("sb_d_rvalid", {31'd0, d_rvalid}, {31'd0, ed});
      check("sb_d_rdata", d_rdata, ed ? ev : 32'd0);
      if (if_flush) check("flush_gnt", {31'd0, if_gnt}, 32'd0);
      if (if_gnt && d_gnt) check("dual_gnt", 32'd1, 32'd0);
      if (if_gnt) begin
        e.due = cyc + 2; e.f = 1; e.data = refm[if_addr];
        q.push_back(e);
      end
      if (d_gnt && d_we) refm[d_addr] = d_wdata;
      if (d_gnt && !d_we) begin
        e.due = cyc + 2; e.f = 0; e.data = refm[d_addr];
        q.push_back(e);
      end
    end
  end

  task automatic go();
    @(posedge clk1);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      go();
      if_req = 0;
      d_req = 0;
      if_flush = 0;
      @(negedge clk1);
    end
  endtask

  bit ft;
  bit dt;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i]  = 32'h1000_0000 + 32'(i * 3);
      refm[i] = 32'h1000_0000 + 32'(i * 3);
    end
    mem[5]  = 32'h2800_000A;
    refm[5] = 32'h2800_000A;
    mem_rdata = '0;
    rst = 1; halted = 0; if_flush = 0;
    if_req = 0; if_addr = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;

    // reset then idle
    for (int i = 0; i < 2; i++) begin
      go();
      rst = 1;
      @(negedge clk1);
      mon_on = (i == 1);
      check("rst_mem_en", {31'd0, mem_en}, 32'd0);
      check("rst_if_gnt", {31'd0, if_gnt}, 32'd0);
      check("rst_d_gnt", {31'd0, d_gnt}, 32'd0);
    end
    go();
    rst = 0;
    @(negedge clk1);
    check("idle_mem_en", {31'd0, mem_en}, 32'd0);
    check("idle_mem_addr", {22'd0, mem_addr}, 32'd0);

    // single fetch
    go();
    if_req = 1; if_addr = 10'd5;
    @(negedge clk1);
    check("f_gnt", {31'd0, if_gnt}, 32'd1);
    go();
    if_req = 0;
    @(negedge clk1);
    check("f_mem_en", {31'd0, mem_en}, 32'd1);
    check("f_mem_addr", {22'd0, mem_addr}, 32'd5);
    check("f_mem_we", {31'd0, mem_we}, 32'd0);
    go();
    @(negedge clk1);
    check("f_rvalid", {31'd0, if_rvalid}, 32'd1);
    check("f_rdata", if_rdata, 32'h2800_000A);
    idle(2);

    // store then load, same address
    go();
    d_req = 1; d_we = 1; d_addr = 10'h3FF; d_wdata = 32'hDEAD_BEEF;
    @(negedge clk1);
    check("st_gnt", {31'd0, d_gnt}, 32'd1);
    go();
    d_we = 0; d_wdata = '0;
    @(negedge clk1);
    check("ld_gnt", {31'd0, d_gnt}, 32'd1);
    check("st_mem_we", {31'd0, mem_we}, 32'd1);
    check("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    go();
    d_req = 0;
    @(negedge clk1);
    check("st_no_rvalid", {31'd0, d_rvalid}, 32'd0);
    go();
    @(negedge clk1);
    check("ld_rvalid", {31'd0, d_rvalid}, 32'd1);
    check("ld_rdata", d_rdata, 32'hDEAD_BEEF);
    idle(2);

    // starvation: 4 data grants then 1 fetch, repeating
    go();
    if_req = 1; if_addr = 10'd10; d_req = 1; d_we = 0; d_addr = 10'd20;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) go();
      @(negedge clk1);
      check("stv_d_gnt", {31'd0, d_gnt}, (i % 5 != 4) ? 32'd1 : 32'd0);
      check("stv_if_gnt", {31'd0, if_gnt}, (i % 5 == 4) ? 32'd1 : 32'd0);
    end
    idle(3);

    // flush
    go();
    if_req = 1; if_addr = 10'd8;
    @(negedge clk1);
    check("fl_gnt0", {31'd0, if_gnt}, 32'd1);
    go();
    if_addr = 10'd9;
    @(negedge clk1);
    check("fl_gnt1", {31'd0, if_gnt}, 32'd1);
    go();
    if_addr = 10'd10; if_flush = 1;
    @(negedge clk1);
    check("fl_gnt2", {31'd0, if_gnt}, 32'd0);
    check("fl_rv2", {31'd0, if_rvalid}, 32'd0);
    go();
    if_flush = 0; if_req = 0;
    @(negedge clk1);
    check("fl_rv3", {31'd0, if_rvalid}, 32'd0);
    idle(3);

    // halt: no fetch grants, loads still complete
    go();
    halted = 1; if_req = 1; if_addr = 10'd3; d_req = 1; d_we = 0; d_addr = 10'd5;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        go();
        d_addr = 10'(6 + i);
      end
      @(negedge clk1);
      check("h_if_gnt", {31'd0, if_gnt}, 32'd0);
      check("h_d_gnt", {31'd0, d_gnt}, 32'd1);
    end
    go();
    d_req = 0; if_flush = 1;
    @(negedge clk1);
    check("h_flush_d_rv", {31'd0, d_rvalid}, 32'd1);
    go();
    if_flush = 0; if_req = 0; halted = 0;
    @(negedge clk1);
    idle(3);

    // reset mid-operation
    go();
    d_req = 1; d_we = 0; d_addr = 10'd7;
    @(negedge clk1);
    check("rm_gnt", {31'd0, d_gnt}, 32'd1);
    go();
    d_req = 0; rst = 1;
    @(negedge clk1);
    go();
    rst = 0;
    @(negedge clk1);
    check("rm_d_rvalid", {31'd0, d_rvalid}, 32'd0);
    check("rm_mem_en", {31'd0, mem_en}, 32'd0);
    check("rm_mem_addr", {22'd0, mem_addr}, 32'd0);
    idle(2);

    // random mixed traffic with hold-until-grant discipline
    ft = 0;
    dt = 0;
    for (int i = 0; i < 80; i++) begin
      go();
      if (!if_req || ft) begin
        if_req = 1'($urandom % 2);
        if_addr = 10'($urandom % 16);
      end
      if (!d_req || dt) begin
        d_req = 1'($urandom % 2);
        d_we = 1'($urandom % 2);
        d_addr = 10'($urandom % 16);
        d_wdata = $urandom;
      end
      @(negedge clk1);
      ft = if_gnt;
      dt = d_gnt;
    end
    idle(6);
    check("sb_drain", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_mem_arbiter.md
Name: mips_mem_arbiter

Overview:
- Shares the single-port unified 1024x32 word memory between two requesters: the IF-stage instruction fetch port and the MEM-stage load/store port.
- Pipelined: at most one new access is granted per cycle, with a fixed 2-cycle read return.
- Data port has priority, and a starvation counter guarantees fetch forward progress.
- Supports halt (block new fetches) and branch flush (discard fetch reads already in flight).

Parameters:
- AW, 10, word-address width (1024 words).
- DW, 32, data width.
- STARVE_MAX, 4, consecutive denied fetch cycles before fetch wins contention; legal range 1..15.

Ports:
- clk1  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous active-high reset.
- halted  in  1  high = no new fetch grants.
- if_flush  in  1  high = cancel return of fetch reads in flight.
- if_req  in  1  fetch request.
- if_addr  in  AW  fetch word address.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  if_rdata valid.
- if_rdata  out  DW  fetched instruction.
- d_req  in  1  data request.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  AW  data word address.
- d_wdata  in  DW  store data.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  d_rdata valid (loads only).
- d_rdata  out  DW  load data.
- mem_en  out  1  memory access strobe (registered).
- mem_we  out  1  memory write enable (registered).
- mem_addr  out  AW  memory address (registered).
- mem_wdata  out  DW  memory write data (registered).
- mem_rdata  in  DW  memory read data; valid the cycle after the mem_en cycle.

Behaviour:
- Reset:
  - mem_en, mem_we, mem_addr, mem_wdata = 0.
  - if_rvalid, d_rvalid = 0.
  - Starvation counter = 0.
  - Both in-flight tags cleared.
  - Reads in flight at reset are dropped: no rvalid for them afterwards.
- Handshake:
  - A requester holds req, addr, we and wdata stable until it sees gnt=1.
  - gnt is combinational from req, the counter and halted. No combinational path from gnt back into req.
  - Request is consumed at the edge where gnt=1.
- Effective fetch request: if_req & ~halted & ~rst. While halted=1, if_gnt=0 regardless of if_req.
- Arbitration, evaluated each cycle:
  - Only one requester active: it is granted.
  - Both active and counter < STARVE_MAX: data granted.
  - Both active and counter == STARVE_MAX: fetch granted.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) on every cycle the effective fetch request is active and if_gnt=0.
  - Cleared on if_gnt=1, and when the effective fetch request is low.
- Issue (grant cycle T):
  - At the edge ending T, mem_en=1, mem_addr/mem_we/mem_wdata are loaded from the winner, and the tag is set: F for fetch, D-load, or D-store.
  - With no grant, mem_en=0 and mem_we=0; addr and wdata hold.
  - Fetches always have mem_we=0.
- Return:
  - Memory samples in T+1; mem_rdata is valid in T+2.
  - In T+2, xx_rvalid=1 for the tag registered in T+1, and xx_rdata = mem_rdata (combinational pass-through, 0 when rvalid=0).
  - Stores never produce rvalid.
  - Back-to-back grants every cycle are legal: throughput is 1 access/cycle and returns stay in order.
- Flush:
  - if_flush=1 in cycle C suppresses if_rvalid for every fetch granted in cycles <= C whose return falls in C, C+1 or C+2.
  - A fetch granted in cycle C itself is not granted at all: if_gnt is forced to 0 during if_flush.
  - Data accesses are unaffected.
  - Flush during halted: no effect beyond suppression.
- Simultaneous store + load to the same address in consecutive grants: executed in grant order; the load in T+1 returns the stored data.
- Idle: mem_en=0; outputs otherwise hold.

Test Plan:
- Reset then idle:
  - Stimulus: rst=1 for 2 cycles, all req=0.
  - Required: mem_en=0, if_gnt=d_gnt=0, rvalid=0 every cycle.
- Single fetch:
  - Stimulus: if_req=1, if_addr=5, cycle T; memory word 5 = 0x2800000A.
  - Required: if_gnt=1 in T; mem_en=1, mem_addr=5, mem_we=0 in T+1; if_rvalid=1, if_rdata=0x2800000A in T+2.
- Store then load to the same address:
  - Stimulus: d_req, we=1, addr=0x3FF, wdata=0xDEADBEEF granted T; load addr=0x3FF granted T+1.
  - Required: d_rvalid=1 only in T+3, with d_rdata=0xDEADBEEF.
- Starvation with STARVE_MAX=4:
  - Stimulus: if_req and d_req both held high continuously.
  - Required: d_gnt=1 for 4 cycles, then if_gnt=1 on the 5th cycle; counter returns to 0; pattern repeats 4:1.
- Flush:
  - Stimulus: fetches to addr 8 and 9 granted T and T+1; if_flush=1 in T+2.
  - Required: if_rvalid=0 in T+2 and T+3; if_gnt=0 in T+2 even with if_req=1.
- Halt and reset mid-operation:
  - Stimulus: halted=1 with if_req=1.
  - Required: if_gnt stays 0 while data loads still complete.
  - Stimulus: a load granted in T, rst=1 in T+1.
  - Required: d_rvalid=0 in T+2 and all state cleared.
